mod_exp_engine: RTL and testbench

//   Sequential modular exponentiator: result = base^exponent mod modulus.

---
 rtl/mod_exp_engine.sv | 188 ++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiator over one shared Blakley multiplier.
// Optional EARLY_TERM_EN macro skips zero-bit multiplies and stops after the top set exponent bit.
module mod_exp_engine #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MUL_R, S_MUL_B, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, b_q, b_d, e_q, e_d, n_q, n_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [IW-1:0]    cnt_q, cnt_d, bit_q, bit_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [WIDTH-1:0] mul_x, prod;
  logic [WIDTH+1:0] acc_in, t, t_red, n1, n2;
  logic             y_bit, mul_last, e_bit, illegal;

  // One Blakley step per cycle; acc reads as zero on the first step of each multiply.
  always_comb begin
    mul_x    = (state_q == S_MUL_R) ? r_q : b_q;
    y_bit    = b_q[LAST - cnt_q];
    acc_in   = (cnt_q == '0) ? '0 : acc_q;
    n1       = {2'b00, n_q};
    n2       = {1'b0, n_q, 1'b0};
    t        = (acc_in << 1) + (y_bit ? {2'b00, mul_x} : '0);
    if (t >= n2)      t_red = t - n2;
    else if (t >= n1) t_red = t - n1;
    else              t_red = t;
    prod     = t_red[WIDTH-1:0];
    mul_last = (cnt_q == LAST);
    e_bit    = e_q[bit_q];
    illegal  = (n_q < WIDTH'(2)) || (b_q >= n_q);
  end

`ifdef EARLY_TERM_EN
  logic [IW:0]      nbit;
  logic [WIDTH-1:0] e_hi;
  always_comb begin
    nbit = {1'b0, bit_q} + (IW+1)'(1);
    e_hi = e_q >> nbit;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      b_q      <= b_d;
      e_q      <= e_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (illegal) state_d = S_FIN;
`ifdef EARLY_TERM_EN
        else if (e_q == '0) state_d = S_FIN;
        else if (e_q[0])    state_d = S_MUL_R;
        else                state_d = S_MUL_B;
`else
        else state_d = S_MUL_R;
`endif
      end
      S_MUL_R: if (mul_last) state_d = S_MUL_B;
      S_MUL_B: begin
        if (mul_last) begin
`ifdef EARLY_TERM_EN
          if (e_hi == '0)   state_d = S_FIN;
          else if (e_hi[0]) state_d = S_MUL_R;
          else              state_d = S_MUL_B;
`else
          state_d = (bit_q == LAST) ? S_FIN : S_MUL_R;
`endif
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_d      = r_q;
    b_d      = b_q;
    e_d      = e_q;
    n_d      = n_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    err_d    = err_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = base;
          e_d     = exponent;
          n_d     = modulus;
          r_d     = WIDTH'(1);
          cnt_d   = '0;
          bit_d   = '0;
          err_d   = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_CHECK: begin
        // Illegal operands flow through FIN with r forced to zero.
        if (illegal) begin
          r_d   = '0;
          err_d = 1'b1;
        end
      end
      S_MUL_R, S_MUL_B: begin
        acc_d = t_red;
        cnt_d = mul_last ? '0 : cnt_q + IW'(1);
        if (mul_last) begin
          if (state_q == S_MUL_B) begin
            b_d   = prod;
            bit_d = bit_q + IW'(1);
          end else if (e_bit) begin
            r_d = prod;
          end
        end
      end
      S_FIN: begin
        result_d = r_q;
        done_d   = 1'b1;
        error_d  = err_q;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

  acc_below_n: assert property (@(posedge clk) disable iff (!reset)
    ((state_q == S_MUL_R || state_q == S_MUL_B) && cnt_q != '0) |-> (acc_q < {2'b00, n_q}));

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed-vector bench for mod_exp_engine at WIDTH=16: table of operations plus
// reset-abort, back-to-back and start-while-busy sequences.
module tb_mod_exp_engine;
  localparam int W     = 16;
  localparam int LAT   = 2 * W * W + 2;
  localparam int LIMIT = LAT + 50;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0, exponent = '0, modulus = '0;
  logic [W-1:0] result;
  logic         busy, done, error;

  int checks = 0;
  int failures = 0;

  mod_exp_engine #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus),
    .result(result), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] b, e, n, res;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < LIMIT);
  endtask

  task automatic run_op(input logic [W-1:0] b, e, n, output logic [W-1:0] res,
                        output logic er, output int lat, output logic bsy);
    @(negedge clk);
    base = b; exponent = e; modulus = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bsy = busy;
    base = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
    wait_done(lat);
    res = result;
    er  = error;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[16];
    logic [W-1:0] res;
    logic         er, bsy;
    int           lat, pulses;

    tbl[0]  = '{"rsa_enc",   16'd65,    16'd17,    16'd3233,  16'd2790,  1'b0};
    tbl[1]  = '{"rsa_dec",   16'd2790,  16'd2753,  16'd3233,  16'd65,    1'b0};
    tbl[2]  = '{"exp_zero",  16'd7,     16'd0,     16'd11,    16'd1,     1'b0};
    tbl[3]  = '{"base_gt_n", 16'd12,    16'd5,     16'd11,    16'd0,     1'b1};
    tbl[4]  = '{"n_one",     16'd0,     16'd3,     16'd1,     16'd0,     1'b1};
    tbl[5]  = '{"n_zero",    16'd0,     16'd3,     16'd0,     16'd0,     1'b1};
    tbl[6]  = '{"base_eq_n", 16'd11,    16'd2,     16'd11,    16'd0,     1'b1};
    tbl[7]  = '{"exp_one",   16'd10,    16'd1,     16'd11,    16'd10,    1'b0};
    tbl[8]  = '{"base_zero", 16'd0,     16'd5,     16'd7,     16'd0,     1'b0};
    tbl[9]  = '{"nmax_sq",   16'd65534, 16'd2,     16'd65535, 16'd1,     1'b0};
    tbl[10] = '{"nmax_cube", 16'd65534, 16'd3,     16'd65535, 16'd65534, 1'b0};
    tbl[11] = '{"pow2",      16'd2,     16'd10,    16'd1000,  16'd24,    1'b0};
    tbl[12] = '{"n_two",     16'd1,     16'd65535, 16'd2,     16'd1,     1'b0};
    tbl[13] = '{"small",     16'd5,     16'd3,     16'd13,    16'd8,     1'b0};
    tbl[14] = '{"exp_ones",  16'd3,     16'd65535, 16'd7,     16'd6,     1'b0};
    tbl[15] = '{"wiki",      16'd4,     16'd13,    16'd497,   16'd445,   1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_busy",   busy,   0);
    check("reset_done",   done,   0);
    check("reset_error",  error,  0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].b, tbl[i].e, tbl[i].n, res, er, lat, bsy);
      check({tbl[i].name, "_result"}, res, tbl[i].res);
      check({tbl[i].name, "_error"},  er,  tbl[i].err);
      check({tbl[i].name, "_busy_on_accept"}, bsy, 1);
      check({tbl[i].name, "_busy_at_done"},   busy, 0);
      if (tbl[i].err) check({tbl[i].name, "_latency"}, lat, 2);
`ifndef EARLY_TERM_EN
      else check({tbl[i].name, "_latency"}, lat, LAT);
`endif
    end

    // Reset pulled mid-MUL_B of exponent bit 2.
    @(negedge clk);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (85) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    check("abort_result", result, 0);
    @(negedge clk) reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < LIMIT; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(16'd4, 16'd13, 16'd497, res, er, lat, bsy);
    check("rerun_result", res, 445);
    check("rerun_error",  er,  0);

    // Back-to-back: start held high across the first done.
    @(negedge clk);
    base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
    @(posedge clk); #1;
    base = 16'd6; exponent = 16'd2; modulus = 16'd7;
    wait_done(lat);
    check("b2b_first_result", result, 2790);
    check("b2b_first_done",   done,   1);
`ifndef EARLY_TERM_EN
    check("b2b_first_latency", lat, LAT);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    wait_done(lat);
    check("b2b_second_result", result, 1);
    check("b2b_second_done",   done,   1);
`ifndef EARLY_TERM_EN
    check("b2b_second_latency", lat, LAT);
`endif

    // Start pulses while busy must be ignored.
    @(negedge clk);
    base = 16'd3; exponent = 16'd5; modulus = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = 16'd2; exponent = 16'd3; modulus = 16'd11;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = (lat % 50 == 0) && (lat < 500);
    end while (!done && lat < LIMIT);
    check("busy_ignore_result", result, 5);
`ifndef EARLY_TERM_EN
    check("busy_ignore_latency", lat, LAT);
`endif
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("busy_ignore_quiet", pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
